// File: rtl/btn_move_queue.sv
// btn_move_queue: synchronise and debounce four direction buttons, queue each clean press as a 2-bit move in a FWFT FIFO.
// Define BTN_REPEAT_EN to add hold-to-repeat of the last pressed direction.
module btn_move_queue #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 30000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic [3:0] btn_state,
    output logic       overflow
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);

    if (DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("btn_move_queue: invalid parameters");
    end

    logic [3:0]    s1_q, s1_d, s2_q, s2_d, stable_q, stable_d, prev_q, prev_d, press;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [1:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   occ_q, occ_d;
    logic          ovf_q, ovf_d, real_press, push_req, pop, push, full;
    logic [1:0]    real_dir, push_dir;

    assign press      = stable_q & ~prev_q;
    assign real_press = |press;
    assign real_dir   = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
    assign full       = occ_q == OCC_FULL;
    assign move_valid = occ_q != '0;
    assign move_dir   = mem_q[rd_q];
    assign btn_state  = stable_q;
    assign overflow   = ovf_q;
    assign pop        = move_valid && move_ready;
    assign push       = push_req && (!full || pop);

    always_comb begin
        s1_d     = {right, left, down, up};
        s2_d     = s1_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) stable_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        mem_d = mem_q;
        if (push) mem_d[wr_q] = push_dir;
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d = ovf_q || (push_req && full && !pop);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    rdir_q, rdir_d;
    logic          ract_q, ract_d, rfirst_q, rfirst_d, rpt_fire;

    // rcnt counts cycles since the last press or repeat; a real press always wins the push slot
    always_comb begin
        rpt_fire = ract_q && stable_q[rdir_q] &&
                   rcnt_q == (rfirst_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD));
        rcnt_d   = rpt_fire ? RW'(1) : ract_q ? rcnt_q + 1'b1 : rcnt_q;
        rdir_d   = rdir_q;
        ract_d   = ract_q && stable_q[rdir_q];
        rfirst_d = rfirst_q && !rpt_fire;
        if (real_press) begin
            rcnt_d   = RW'(1);
            rdir_d   = real_dir;
            ract_d   = 1'b1;
            rfirst_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rcnt_q   <= '0;
            rdir_q   <= '0;
            ract_q   <= 1'b0;
            rfirst_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rdir_q   <= rdir_d;
            ract_q   <= ract_d;
            rfirst_q <= rfirst_d;
        end
    end

    assign push_req = real_press || rpt_fire;
    assign push_dir = real_press ? real_dir : rdir_q;
`else
    assign push_req = real_press;
    assign push_dir = real_dir;
`endif
endmodule

// File: tb/tb_btn_move_queue.sv
// tb_btn_move_queue: directed tables, hand sequences and random stimulus against a queue-based reference model.
module tb_btn_move_queue;
    localparam int D = 4, DEPTH = 4, RD = 10, RP = 5;

    logic       clk = 0, clr = 0, up = 0, down = 0, left = 0, right = 0, move_ready = 0;
    logic       move_valid, overflow;
    logic [1:0] move_dir;
    logic [3:0] btn_state;
    logic [3:0] b = 0;
    int         n_cmp = 0, n_bad = 0, cyc = 0;

    always #5 clk = ~clk;

    btn_move_queue #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .clr(clr), .up(up), .down(down), .left(left), .right(right),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .btn_state(btn_state), .overflow(overflow)
    );

    // Reference model: raw sample history, debounced levels, command queue, repeat schedule
    logic [1:0] mq[$];
    logic [3:0] hist[$];
    logic [3:0] m_stable = 0, m_rise = 0;
    bit         m_ovf = 0, r_act = 0;
    logic [1:0] r_dir = 0;
    int         r_next = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(4'b0);
        m_stable = 0;
        m_rise   = 0;
        m_ovf    = 0;
        r_act    = 0;
    endtask

    task automatic model_edge();
        logic [3:0] s;
        logic [1:0] dir;
        bit req, pop, rpt, all_diff;
        cyc++;
        if (!clr) begin
            model_reset();
            return;
        end
        rpt = 0;
`ifdef BTN_REPEAT_EN
        if (r_act && !m_stable[r_dir]) r_act = 0;
        rpt = r_act && cyc == r_next;
        if (rpt) r_next = cyc + RP;
`endif
        req = (m_rise != 0) || rpt;
        dir = m_rise[0] ? 2'd0 : m_rise[1] ? 2'd1 : m_rise[2] ? 2'd2 : m_rise[3] ? 2'd3 : r_dir;
        if (m_rise != 0) begin
            r_act  = 1;
            r_dir  = dir;
            r_next = cyc + RD;
        end
        pop = mq.size() > 0 && move_ready;
        if (pop) void'(mq.pop_front());
        if (req) begin
            if (mq.size() < DEPTH) mq.push_back(dir);
            else m_ovf = 1;
        end
        // a level is accepted once the synchronised samples (two edges old) disagreed D times in a row
        hist.push_back({right, left, down, up});
        if (hist.size() > 32) void'(hist.pop_front());
        s = m_stable;
        for (int k = 0; k < 4; k++) begin
            all_diff = 1;
            for (int j = 0; j < D; j++)
                if (hist[hist.size() - 3 - j][k] == m_stable[k]) all_diff = 0;
            if (all_diff) s[k] = ~m_stable[k];
        end
        m_rise   = s & ~m_stable;
        m_stable = s;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_valid", int'(move_valid), int'(mq.size() != 0));
        if (mq.size() != 0) chk("model_dir", int'(move_dir), int'(mq[0]));
        chk("model_btn", int'(btn_state), int'(m_stable));
        chk("model_ovf", int'(overflow), int'(m_ovf));
    endtask

    task automatic set_btn(input logic [3:0] v);
        b = v;
        {right, left, down, up} = v;
    endtask

    task automatic drain();
        move_ready = 1;
        repeat (12) tick();
        move_ready = 0;
    endtask

    typedef struct {
        logic [3:0] btns;
        logic [1:0] exp_dir;
        logic [3:0] exp_state;
    } vec_t;
    vec_t vt[7];
    int   offs[$];
    int   exp_offs[$];
    int   cnt, t_btn, t_val, t0;

    initial begin
        vt[0] = '{4'b0001, 2'd0, 4'b0001};
        vt[1] = '{4'b0101, 2'd0, 4'b0101};
        vt[2] = '{4'b0010, 2'd1, 4'b0010};
        vt[3] = '{4'b1100, 2'd2, 4'b1100};
        vt[4] = '{4'b1000, 2'd3, 4'b1000};
        vt[5] = '{4'b1110, 2'd1, 4'b1110};
        vt[6] = '{4'b1111, 2'd0, 4'b1111};
        model_reset();

        // reset held with toggling buttons
        for (int i = 0; i < 8; i++) begin
            set_btn(4'($urandom));
            tick();
            chk("rst_outputs", int'({move_valid, move_dir, btn_state, overflow}), 0);
        end
        set_btn(0);
        tick();
        clr = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_valid", int'(move_valid), 0);
        end

        // bounce on down, then hold
        for (int i = 0; i < 20; i++) begin
            set_btn({2'b00, ((i >> 1) & 1) == 0, 1'b0});
            tick();
        end
        set_btn(4'b0010);
        t_btn = 0;
        t_val = 0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (btn_state[1] && t_btn == 0) t_btn = t;
            if (move_valid && t_val == 0) t_val = t;
        end
        chk("bounce_btn_rise", t_btn, D + 2);
        chk("bounce_valid_rise", t_val, D + 3);
        chk("bounce_dir", int'(move_dir), 1);
        move_ready = 1;
        tick();
        move_ready = 0;
        chk("bounce_one_entry", int'(move_valid), 0);
        set_btn(0);
        drain();

        // single right press, consumer always ready
        move_ready = 1;
        set_btn(4'b1000);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) set_btn(0);
            tick();
            if (move_valid) begin
                cnt++;
                chk("single_dir", int'(move_dir), 3);
            end
        end
        chk("single_valid_cycles", cnt, 1);
        move_ready = 0;

        // table: simultaneous presses and priority
        foreach (vt[i]) begin
            set_btn(vt[i].btns);
            repeat (8) tick();
            chk("vec_btn_state", int'(btn_state), int'(vt[i].exp_state));
            chk("vec_valid", int'(move_valid), 1);
            chk("vec_dir", int'(move_dir), int'(vt[i].exp_dir));
            move_ready = 1;
            tick();
            move_ready = 0;
            chk("vec_one_entry", int'(move_valid), 0);
            set_btn(0);
            repeat (8) tick();
        end
        drain();

        // overflow: five down presses with no consumer
        for (int p = 0; p < 5; p++) begin
            set_btn(4'b0010);
            repeat (8) tick();
            set_btn(0);
            repeat (8) tick();
        end
        chk("ovf_set", int'(overflow), 1);
        move_ready = 1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (!move_valid) break;
            cnt++;
            chk("ovf_pop_dir", int'(move_dir), 1);
            tick();
        end
        chk("ovf_pop_count", cnt, 4);
        chk("ovf_sticky", int'(overflow), 1);
        move_ready = 0;

        // hold left long after debounce
        move_ready = 1;
        set_btn(4'b0100);
        t0 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (move_valid) begin
                t0 = 1;
                break;
            end
        end
        chk("rpt_first_seen", t0, 1);
        chk("rpt_first_dir", int'(move_dir), 2);
        offs.delete();
        for (int t = 1; t <= 28; t++) begin
            tick();
            if (move_valid) begin
                offs.push_back(t);
                chk("rpt_dir", int'(move_dir), 2);
            end
        end
        exp_offs.delete();
`ifdef BTN_REPEAT_EN
        exp_offs = '{10, 15, 20, 25};
`endif
        chk("rpt_count", offs.size(), exp_offs.size());
        foreach (exp_offs[i]) if (i < offs.size()) chk("rpt_offset", offs[i], exp_offs[i]);
        set_btn(0);
        drain();

        // random buttons and consumer, with one mid-run reset
        clr = 0;
        tick();
        clr = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                b[$urandom_range(0, 3)] ^= 1'b1;
                set_btn(b);
            end
            move_ready = $urandom_range(0, 2) == 0;
            if (i == 700) clr = 0;
            if (i == 702) clr = 1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
